// File: rtl/ddr2_sys_ddr2_dmaster_b2p.sv
// rtl/ddr2_sys_ddr2_dmaster_b2p.sv - bytes-to-packets decoder for the debug-master stream path
//
// Strips the in-band control characters from a raw byte stream and emits
// Avalon-ST beats carrying start/end-of-packet and a sticky 8-bit channel.
//   0x7A start-of-packet marker, 0x7B end-of-packet marker,
//   0x7C channel marker (next literal is the channel), 0x7D escape (next byte ^ 0x20).
//
// Ports:
//   clk                 in   single clock, rising edge
//   reset               in   synchronous, active-high
//   in_ready            out  byte stream ready (combinational from out_valid/out_ready)
//   in_valid            in   byte stream valid
//   in_data[7:0]        in   raw byte including control characters
//   out_ready           in   downstream ready
//   out_valid           out  registered beat valid
//   out_data[7:0]       out  decoded payload byte
//   out_channel[7:0]    out  channel presented with every beat
//   out_startofpacket   out  first beat of packet
//   out_endofpacket     out  last beat of packet

module ddr2_sys_ddr2_dmaster_b2p (
    input  logic       clk,
    input  logic       reset,
    output logic       in_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [7:0] out_channel,
    output logic       out_startofpacket,
    output logic       out_endofpacket
);

    localparam logic [7:0] SOP_CHAR  = 8'h7A;
    localparam logic [7:0] EOP_CHAR  = 8'h7B;
    localparam logic [7:0] CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ESC_CHAR  = 8'h7D;

    logic       esc_q,  esc_d;
    logic       chan_q, chan_d;
    logic       sop_q,  sop_d;
    logic       eop_q,  eop_d;
    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;
    logic [7:0] ch_q,   ch_d;
    logic       osop_q, osop_d;
    logic       oeop_q, oeop_d;

    logic       accept;
    logic       is_lit;
    logic [7:0] lit;

    // Single output register: a new byte may enter whenever the slot is
    // empty or is being drained this cycle.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        esc_d   = esc_q;
        chan_d  = chan_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        osop_d  = osop_q;
        oeop_d  = oeop_q;
        is_lit  = 1'b0;
        lit     = in_data;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (esc_q) begin
                // Escaped bytes are always literals, even if they decode to a marker value.
                lit    = in_data ^ 8'h20;
                esc_d  = 1'b0;
                is_lit = 1'b1;
            end else begin
                case (in_data)
                    ESC_CHAR:  esc_d  = 1'b1;
                    SOP_CHAR:  sop_d  = 1'b1;
                    EOP_CHAR:  eop_d  = 1'b1;
                    CHAN_CHAR: chan_d = 1'b1;
                    default:   is_lit = 1'b1;
                endcase
            end

            if (is_lit) begin
                if (chan_q) begin
                    ch_d   = lit;
                    chan_d = 1'b0;
                end else begin
                    data_d  = lit;
                    osop_d  = sop_q;
                    oeop_d  = eop_q;
                    valid_d = 1'b1;
                    sop_d   = 1'b0;
                    eop_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            esc_q   <= 1'b0;
            chan_q  <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            ch_q    <= 8'h00;
            osop_q  <= 1'b0;
            oeop_q  <= 1'b0;
        end else begin
            esc_q   <= esc_d;
            chan_q  <= chan_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            osop_q  <= osop_d;
            oeop_q  <= oeop_d;
        end
    end

    assign out_valid         = valid_q;
    assign out_data          = data_q;
    assign out_channel       = ch_q;
    assign out_startofpacket = osop_q;
    assign out_endofpacket   = oeop_q;

endmodule

// File: tb/tb_ddr2_sys_ddr2_dmaster_b2p.sv
// tb/tb_ddr2_sys_ddr2_dmaster_b2p.sv - self-checking bench for the bytes-to-packets decoder

module tb_ddr2_sys_ddr2_dmaster_b2p;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] out_channel;
    logic       out_startofpacket;
    logic       out_endofpacket;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr2_sys_ddr2_dmaster_b2p dut (
        .clk               (clk),
        .reset             (reset),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ev;
        logic [7:0] ed;
        logic [7:0] ech;
        logic       esop;
        logic       eeop;
        logic       eir;
    } vec_t;

    vec_t vecs[$];

    typedef struct {
        logic [7:0] data;
        logic [7:0] ch;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t exp_q[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    // Row: inputs driven before an edge, expected outputs just after it.
    // in_ready after the edge follows from the registered valid and the still-driven out_ready.
    task automatic add(input logic rst, input logic iv, input logic [7:0] id, input logic ordy,
                       input logic ev, input logic [7:0] ed, input logic [7:0] ech,
                       input logic esop, input logic eeop);
        vec_t v;
        v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.ech = ech; v.esop = esop; v.eeop = eeop;
        v.eir = !ev || ordy;
        vecs.push_back(v);
    endtask

    task automatic byte_row(input logic [7:0] b, input logic ev, input logic [7:0] ed,
                            input logic [7:0] ech, input logic esop, input logic eeop);
        add(1'b0, 1'b1, b, 1'b1, ev, ed, ech, esop, eeop);
    endtask

    // Reference decoder state
    logic       m_esc, m_chan, m_sop, m_eop;
    logic [7:0] m_ch;

    task automatic model_reset();
        m_esc = 0; m_chan = 0; m_sop = 0; m_eop = 0; m_ch = 8'h00;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] v;
        beat_t bt;
        if (!m_esc && b == 8'h7D) begin m_esc = 1; return; end
        if (!m_esc && b == 8'h7A) begin m_sop = 1; return; end
        if (!m_esc && b == 8'h7B) begin m_eop = 1; return; end
        if (!m_esc && b == 8'h7C) begin m_chan = 1; return; end
        v = m_esc ? (b ^ 8'h20) : b;
        m_esc = 0;
        if (m_chan) begin
            m_ch = v;
            m_chan = 0;
        end else begin
            bt.data = v; bt.ch = m_ch; bt.sop = m_sop; bt.eop = m_eop;
            exp_q.push_back(bt);
            m_sop = 0; m_eop = 0;
        end
    endtask

    logic       stall_prev;
    logic [7:0] hold_d, hold_ch;
    logic       hold_s, hold_e;

    task automatic random_cycle(input logic iv, input logic [7:0] id, input logic ordy);
        beat_t bt;
        @(posedge clk);
        #1;
        in_valid = iv; in_data = id; out_ready = ordy;
        @(negedge clk);
        chk("rnd_in_ready", {7'd0, in_ready}, {7'd0, (!out_valid || out_ready)});
        if (stall_prev) begin
            chk("rnd_hold_valid", {7'd0, out_valid}, 8'h01);
            chk("rnd_hold_data", out_data, hold_d);
            chk("rnd_hold_ch", out_channel, hold_ch);
            chk("rnd_hold_flags", {6'd0, out_startofpacket, out_endofpacket}, {6'd0, hold_s, hold_e});
        end
        stall_prev = out_valid && !out_ready;
        hold_d = out_data; hold_ch = out_channel;
        hold_s = out_startofpacket; hold_e = out_endofpacket;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rnd_extra_beat: got data %02h expected no beat", out_data);
            end else begin
                bt = exp_q.pop_front();
                chk("rnd_data", out_data, bt.data);
                chk("rnd_ch", out_channel, bt.ch);
                chk("rnd_sop_eop", {6'd0, out_startofpacket, out_endofpacket}, {6'd0, bt.sop, bt.eop});
            end
        end
        if (iv && in_ready) model_byte(id);
    endtask

    initial begin
        logic [7:0] b;
        reset = 1; in_valid = 0; in_data = 8'h00; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {7'd0, out_valid}, 8'h00);
        chk("reset_data", out_data, 8'h00);
        chk("reset_ch", out_channel, 8'h00);
        chk("reset_in_ready", {7'd0, in_ready}, 8'h01);
        reset = 0;

        // Basic packet
        byte_row(8'h7A, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h7C, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h00, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h11, 1, 8'h11, 8'h00, 1, 0);
        byte_row(8'h22, 1, 8'h22, 8'h00, 0, 0);
        byte_row(8'h7B, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h33, 1, 8'h33, 8'h00, 0, 1);
        add(0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0);
        // Escapes
        byte_row(8'h7A, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h7D, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h5A, 1, 8'h7A, 8'h00, 1, 0);
        byte_row(8'h7D, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h5D, 1, 8'h7D, 8'h00, 0, 0);
        byte_row(8'h7B, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h7D, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h5B, 1, 8'h7B, 8'h00, 0, 1);
        // Channel set through an escape, SOP and EOP on one beat, sticky channel
        byte_row(8'h7C, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h7D, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h5C, 0, 8'h00, 8'h7C, 0, 0);
        byte_row(8'h7A, 0, 8'h00, 8'h7C, 0, 0);
        byte_row(8'h7B, 0, 8'h00, 8'h7C, 0, 0);
        byte_row(8'h44, 1, 8'h44, 8'h7C, 1, 1);
        byte_row(8'h55, 1, 8'h55, 8'h7C, 0, 0);
        // Escaped channel marker is data
        byte_row(8'h7D, 0, 8'h00, 8'h7C, 0, 0);
        byte_row(8'h5C, 1, 8'h7C, 8'h7C, 0, 0);
        // Backpressure: beat 11 held five cycles, then 22 accepted on release
        byte_row(8'h11, 1, 8'h11, 8'h7C, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 8'h22, 0, 1, 8'h11, 8'h7C, 0, 0);
        byte_row(8'h22, 1, 8'h22, 8'h7C, 0, 0);
        add(0, 0, 8'h00, 1, 0, 8'h00, 8'h7C, 0, 0);
        // Reset mid-escape
        byte_row(8'h7D, 0, 8'h00, 8'h7C, 0, 0);
        add(1, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h41, 1, 8'h41, 8'h00, 0, 0);
        // Reset with a pending channel marker
        byte_row(8'h7C, 0, 8'h00, 8'h00, 0, 0);
        add(1, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h7A, 0, 8'h00, 8'h00, 0, 0);
        byte_row(8'h66, 1, 8'h66, 8'h00, 1, 0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; in_valid = vecs[i].iv;
            in_data = vecs[i].id; out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {7'd0, out_valid}, {7'd0, vecs[i].ev});
            chk($sformatf("v%0d_ch", i), out_channel, vecs[i].ech);
            chk($sformatf("v%0d_in_ready", i), {7'd0, in_ready}, {7'd0, vecs[i].eir});
            if (vecs[i].ev || vecs[i].rst) begin
                chk($sformatf("v%0d_data", i), out_data, vecs[i].ed);
                chk($sformatf("v%0d_sop_eop", i), {6'd0, out_startofpacket, out_endofpacket},
                    {6'd0, vecs[i].esop, vecs[i].eeop});
            end
        end
        reset = 0; in_valid = 0;

        // Randomized traffic against the reference decoder
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        stall_prev = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(1, 0) == 0)
                b = 8'h7A + 8'($urandom_range(3, 0));
            else
                b = 8'($urandom);
            random_cycle($urandom_range(3, 0) != 0, b, $urandom_range(2, 0) != 0);
        end
        for (int i = 0; i < 4; i++) random_cycle(1'b0, 8'h00, 1'b1);
        chk("rnd_queue_drained", 8'(exp_q.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
